// File: rtl/mem_req_arbiter_if.sv
// SRAM-like request/response bundle used by both pipeline masters and the memory-side slave port.
// The master modport drives the request; the slave modport answers with addr_ok/data_ok/rdata.
interface mem_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Two-master (inst/data) to one-slave SRAM-like arbiter with in-order ID FIFO for response routing.
// Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin grant; default is fixed data priority.
module mem_req_arbiter #(
  parameter int OT_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_req_arbiter_if.slave       inst_sram,
  mem_req_arbiter_if.slave       data_sram,
  mem_req_arbiter_if.master      mem,
  output logic                   arb_err
);

  localparam int AW = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;
  localparam logic [AW:0] W_FULL_CNT = (AW + 1)'(OT_DEPTH);

  // Master IDs: 0 = inst, 1 = data
  logic          w_req_i;
  logic          w_req_d;
  logic          w_gnt_vld;
  logic          w_gnt_id;
  logic          w_held_req;
  logic          w_hold_live;
  logic          w_full;
  logic          w_empty;
  logic          w_mem_req;
  logic          w_push;
  logic          w_pop;
  logic          w_head_id;
  logic          w_hold_next;
  logic          w_hold_id_next;

  logic          r_hold;
  logic          r_hold_id;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_arb_err;
  logic          r_id_mem [OT_DEPTH];

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic          r_last;
`endif

  assign w_req_i     = inst_sram.req;
  assign w_req_d     = data_sram.req;
  assign w_gnt_vld   = w_req_i | w_req_d;
  assign w_held_req  = r_hold_id ? w_req_d : w_req_i;
  assign w_hold_live = r_hold & w_held_req;

  always_comb begin
    w_gnt_id = 1'b0;
    if (w_hold_live) begin
      w_gnt_id = r_hold_id;
    end else if (w_req_i && w_req_d) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      w_gnt_id = ~r_last;
`else
      w_gnt_id = 1'b1;
`endif
    end else begin
      w_gnt_id = w_req_d;
    end
  end

  assign w_full    = (r_count == W_FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_mem_req = w_gnt_vld & ~w_full;
  assign w_push    = w_mem_req & mem.addr_ok;
  assign w_pop     = mem.data_ok & ~w_empty;
  assign w_head_id = r_id_mem[r_rptr];

  assign mem.req = w_mem_req;

  // Request fields follow the grant even when full; only req itself is throttled.
  always_comb begin
    mem.wr    = 1'b0;
    mem.size  = 2'd0;
    mem.wstrb = 4'd0;
    mem.addr  = 32'd0;
    mem.wdata = 32'd0;
    if (w_gnt_vld) begin
      if (w_gnt_id) begin
        mem.wr    = data_sram.wr;
        mem.size  = data_sram.size;
        mem.wstrb = data_sram.wstrb;
        mem.addr  = data_sram.addr;
        mem.wdata = data_sram.wdata;
      end else begin
        mem.wr    = inst_sram.wr;
        mem.size  = inst_sram.size;
        mem.wstrb = inst_sram.wstrb;
        mem.addr  = inst_sram.addr;
        mem.wdata = inst_sram.wdata;
      end
    end
  end

  assign inst_sram.addr_ok = w_push & ~w_gnt_id;
  assign data_sram.addr_ok = w_push &  w_gnt_id;
  assign inst_sram.data_ok = w_pop  & ~w_head_id;
  assign data_sram.data_ok = w_pop  &  w_head_id;
  assign inst_sram.rdata   = mem.rdata;
  assign data_sram.rdata   = mem.rdata;
  assign arb_err           = r_arb_err;

  // A stalled handshake pins the grant; a flush by the held master releases it.
  always_comb begin
    w_hold_next    = r_hold;
    w_hold_id_next = r_hold_id;
    if (w_push) begin
      w_hold_next = 1'b0;
    end else if (w_mem_req) begin
      w_hold_next    = 1'b1;
      w_hold_id_next = w_gnt_id;
    end else if (r_hold && !w_held_req) begin
      w_hold_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold    <= 1'b0;
      r_hold_id <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_arb_err <= 1'b0;
    end else begin
      r_hold    <= w_hold_next;
      r_hold_id <= w_hold_id_next;
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (mem.data_ok && w_empty) begin
        r_arb_err <= 1'b1;
      end
    end
  end

  // ID storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_id_mem[r_wptr] <= w_gnt_id;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Resets to data so that inst wins the first contested cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (w_push) begin
      r_last <= w_gnt_id;
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_mem_req_arbiter;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  logic arb_err;

  mem_req_arbiter_if inst_if();
  mem_req_arbiter_if data_if();
  mem_req_arbiter_if mem_if();

  mem_req_arbiter #(.OT_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .inst_sram (inst_if),
    .data_sram (data_if),
    .mem       (mem_if),
    .arb_err   (arb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: queue of issuing masters in acceptance order, pinned grant, RR last winner, error flag.
  bit m_q[$];
  bit m_hold    = 1'b0;
  bit m_hold_id = 1'b0;
  bit m_last    = 1'b1;
  bit m_err     = 1'b0;
  bit acc_i     = 1'b0;
  bit acc_d     = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit          req[2];
    bit          gv;
    bit          g;
    bit          e_req;
    bit          e_acc;
    bit          e_pop;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic [1:0]  e_size;
    logic        e_wr;
    if (reset) begin
      m_q.delete();
      m_hold = 1'b0;
      m_hold_id = 1'b0;
      m_last = 1'b1;
      m_err = 1'b0;
    end
    req[0] = inst_if.req;
    req[1] = data_if.req;
    gv = req[0] | req[1];
    if (m_hold && req[m_hold_id]) g = m_hold_id;
    else if (req[0] && req[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      g = !m_last;
`else
      g = 1'b1;
`endif
    end else g = req[1];
    e_req = gv && (m_q.size() < DEPTH);
    e_wr = 0; e_size = 0; e_wstrb = 0; e_addr = 0; e_wdata = 0;
    if (gv) begin
      e_wr    = g ? data_if.wr    : inst_if.wr;
      e_size  = g ? data_if.size  : inst_if.size;
      e_wstrb = g ? data_if.wstrb : inst_if.wstrb;
      e_addr  = g ? data_if.addr  : inst_if.addr;
      e_wdata = g ? data_if.wdata : inst_if.wdata;
    end
    e_acc = e_req && mem_if.addr_ok;
    e_pop = mem_if.data_ok && (m_q.size() > 0);
    chk("mem_req",   32'(mem_if.req),   32'(e_req));
    chk("mem_wr",    32'(mem_if.wr),    32'(e_wr));
    chk("mem_size",  32'(mem_if.size),  32'(e_size));
    chk("mem_wstrb", 32'(mem_if.wstrb), 32'(e_wstrb));
    chk("mem_addr",  mem_if.addr,       e_addr);
    chk("mem_wdata", mem_if.wdata,      e_wdata);
    chk("inst_addr_ok", 32'(inst_if.addr_ok), 32'(e_acc && !g));
    chk("data_addr_ok", 32'(data_if.addr_ok), 32'(e_acc && g));
    chk("inst_data_ok", 32'(inst_if.data_ok), 32'(e_pop && m_q[0] == 1'b0));
    chk("data_data_ok", 32'(data_if.data_ok), 32'(e_pop && m_q[0] == 1'b1));
    chk("inst_rdata", inst_if.rdata, mem_if.rdata);
    chk("data_rdata", data_if.rdata, mem_if.rdata);
    chk("arb_err", 32'(arb_err), 32'(m_err));
    acc_i = e_acc && !g;
    acc_d = e_acc && g;
    if (!reset) begin
      if (mem_if.data_ok) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_err = 1'b1;
      end
      if (e_acc) begin
        m_q.push_back(g);
        m_last = g;
        m_hold = 1'b0;
      end else if (e_req) begin
        m_hold = 1'b1;
        m_hold_id = g;
      end else if (m_hold && !req[m_hold_id]) begin
        m_hold = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit m, input bit rq, input bit wr, input logic [1:0] sz,
                         input logic [3:0] st, input logic [31:0] a, input logic [31:0] wd);
    if (!m) begin
      inst_if.req = rq; inst_if.wr = wr; inst_if.size = sz;
      inst_if.wstrb = st; inst_if.addr = a; inst_if.wdata = wd;
    end else begin
      data_if.req = rq; data_if.wr = wr; data_if.size = sz;
      data_if.wstrb = st; data_if.addr = a; data_if.wdata = wd;
    end
  endtask

  task automatic clr();
    set_req(0, 0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0, 0);
    mem_if.addr_ok = 0;
    mem_if.data_ok = 0;
    mem_if.rdata   = 0;
  endtask

  task automatic rd(input bit m, input logic [31:0] a);
    set_req(m, 1, 0, 2'd2, 4'hF, a, 32'd0);
  endtask

  initial begin
    bit exp_d;
    bit cur;
    clr();
    reset = 1'b1;
    tick(); tick();
    chk("pin_rst_mem_req", 32'(mem_if.req), 32'd0);
    chk("pin_rst_arb_err", 32'(arb_err), 32'd0);
    reset = 1'b0;

    // Both masters request continuously
    for (int c = 0; c < 4; c++) begin
      rd(0, 32'h100 + 32'(c));
      rd(1, 32'h200 + 32'(c));
      mem_if.addr_ok = 1;
      mem_if.data_ok = (c > 0);
      #5;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_d = (c % 2 == 1);
`else
      exp_d = 1'b1;
`endif
      chk("pin_both_data_gnt", 32'(data_if.addr_ok), 32'(exp_d));
      chk("pin_both_inst_gnt", 32'(inst_if.addr_ok), 32'(!exp_d));
      tick();
    end
    clr();
    mem_if.data_ok = 1;
    tick();
    clr();

    // Single inst read
    rd(0, 32'h1C00_0000);
    mem_if.addr_ok = 1;
    #5;
    chk("pin_t1_inst_addr_ok", 32'(inst_if.addr_ok), 32'd1);
    chk("pin_t1_mem_addr", mem_if.addr, 32'h1C00_0000);
    chk("pin_t1_data_addr_ok", 32'(data_if.addr_ok), 32'd0);
    tick();
    clr();
    tick();
    mem_if.data_ok = 1;
    mem_if.rdata = 32'hDEADBEEF;
    #5;
    chk("pin_t1_inst_data_ok", 32'(inst_if.data_ok), 32'd1);
    chk("pin_t1_inst_rdata", inst_if.rdata, 32'hDEADBEEF);
    chk("pin_t1_data_data_ok", 32'(data_if.data_ok), 32'd0);
    tick();
    clr();

    // Stalled inst request keeps the grant while data arrives
    for (int c = 0; c < 4; c++) begin
      rd(0, 32'h1C00_0010);
      if (c >= 1) rd(1, 32'h8000_0000);
      mem_if.addr_ok = (c == 3);
      #5;
      chk("pin_hold_mem_addr", mem_if.addr, 32'h1C00_0010);
      tick();
    end
    set_req(0, 0, 0, 0, 0, 0, 0);
    #5;
    chk("pin_hold_data_addr_ok", 32'(data_if.addr_ok), 32'd1);
    chk("pin_hold_data_mem_addr", mem_if.addr, 32'h8000_0000);
    tick();
    clr();
    mem_if.data_ok = 1;
    #5;
    chk("pin_hold_drain_inst", 32'(inst_if.data_ok), 32'd1);
    tick();
    #5;
    chk("pin_hold_drain_data", 32'(data_if.data_ok), 32'd1);
    tick();
    clr();

    // Fill to depth, then pop and push together
    for (int c = 0; c < 4; c++) begin
      rd(1, 32'h300 + 32'(4 * c));
      mem_if.addr_ok = 1;
      #5;
      chk("pin_full_fill", 32'(data_if.addr_ok), 32'd1);
      tick();
    end
    rd(1, 32'h400);
    #5;
    chk("pin_full_mem_req", 32'(mem_if.req), 32'd0);
    chk("pin_full_addr_ok", 32'(data_if.addr_ok), 32'd0);
    tick();
    mem_if.data_ok = 1;
    #5;
    chk("pin_full_pop_d", 32'(data_if.data_ok), 32'd1);
    chk("pin_full_mem_req2", 32'(mem_if.req), 32'd0);
    tick();
    set_req(1, 0, 0, 0, 0, 0, 0);
    rd(0, 32'h500);
    #5;
    chk("pin_pushpop_inst_acc", 32'(inst_if.addr_ok), 32'd1);
    chk("pin_pushpop_pop_d", 32'(data_if.data_ok), 32'd1);
    tick();
    mem_if.data_ok = 0;
    rd(0, 32'h504);
    #5;
    chk("pin_refill_inst_acc", 32'(inst_if.addr_ok), 32'd1);
    tick();
    rd(0, 32'h508);
    #5;
    chk("pin_refull_mem_req", 32'(mem_if.req), 32'd0);
    tick();
    clr();
    for (int c = 0; c < 4; c++) begin
      mem_if.data_ok = 1;
      #5;
      chk("pin_full_drain_d", 32'(data_if.data_ok), 32'(c < 2));
      chk("pin_full_drain_i", 32'(inst_if.data_ok), 32'(c >= 2));
      tick();
    end
    clr();

    // Interleaved I, D, I then responses, then orphan
    for (int c = 0; c < 3; c++) begin
      clr();
      rd(c == 1, 32'h600 + 32'(c));
      mem_if.addr_ok = 1;
      tick();
    end
    clr();
    for (int c = 0; c < 3; c++) begin
      mem_if.data_ok = 1;
      #5;
      chk("pin_route_inst", 32'(inst_if.data_ok), 32'(c != 1));
      chk("pin_route_data", 32'(data_if.data_ok), 32'(c == 1));
      tick();
    end
    chk("pin_err_before_orphan", 32'(arb_err), 32'd0);
    #5;
    chk("pin_orphan_no_ok", 32'(inst_if.data_ok | data_if.data_ok), 32'd0);
    tick();
    mem_if.data_ok = 0;
    chk("pin_err_set", 32'(arb_err), 32'd1);
    tick();
    chk("pin_err_sticky", 32'(arb_err), 32'd1);

    // Asynchronous reset with two outstanding
    for (int c = 0; c < 2; c++) begin
      rd(0, 32'h700 + 32'(c));
      mem_if.addr_ok = 1;
      tick();
    end
    clr();
    mem_if.data_ok = 1;
    #1;
    chk("pin_prerst_inst_data_ok", 32'(inst_if.data_ok), 32'd1);
    chk("pin_prerst_arb_err", 32'(arb_err), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("pin_arst_inst_data_ok", 32'(inst_if.data_ok), 32'd0);
    chk("pin_arst_data_data_ok", 32'(data_if.data_ok), 32'd0);
    chk("pin_arst_arb_err", 32'(arb_err), 32'd0);
    tick();
    clr();
    reset = 1'b0;
    tick();

    // Randomized traffic obeying the hold-until-accepted protocol, with occasional flushes
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        cur = (m == 0) ? inst_if.req : data_if.req;
        if (!cur || ((m == 0) ? acc_i : acc_d)) begin
          if ($urandom_range(0, 1) == 1)
            set_req(m[0], 1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                    4'($urandom), $urandom, $urandom);
          else
            set_req(m[0], 0, 0, 0, 0, 0, 0);
        end else if ($urandom_range(0, 15) == 0) begin
          set_req(m[0], 0, 0, 0, 0, 0, 0);
        end
      end
      mem_if.addr_ok = 1'($urandom_range(0, 1));
      mem_if.data_ok = (m_q.size() > 0) && ($urandom_range(0, 2) != 0);
      mem_if.rdata   = $urandom;
      tick();
    end
    clr();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
